// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg: shared timing, opcode and condition constants for the control unit
package control_sequencer_pkg;
    localparam logic [3:0] STEP_T1 = 4'b0001;
    localparam logic [3:0] STEP_T2 = 4'b0010;
    localparam logic [3:0] STEP_T3 = 4'b0100;
    localparam logic [3:0] STEP_T4 = 4'b1000;
    localparam logic [7:0] COUNT_FIRST = 8'h01;
    localparam logic [7:0] COUNT_LAST = 8'h80;
    localparam logic [7:0] OPC_NOP = 8'h00;
    localparam logic [7:0] OPC_CB = 8'hCB;
    localparam int COND_NZ = 0;
    localparam int COND_Z = 1;
    localparam int COND_NC = 2;
    localparam int COND_C = 3;
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 0;
endpackage

// File: rtl/control_sequencer_step_ring.sv
// step_ring: 4-bit one-hot T-step rotator with hold and synchronous reset
module step_ring
    import control_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       hold,
    output logic [3:0] step
);
    always_ff @(posedge clk) begin
        if (rst)
            step <= STEP_T1;
        else if (!hold)
            step <= {step[2:0], step[3]};
    end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: T-step/M-cycle timing, opcode latch and condition decode for the microcode blocks
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Stall,
    input  logic       i_IR_Fetch,
    input  logic [7:0] i_Data_Bus,
    input  logic [3:0] i_Flags,
    output logic [3:0] o_Cycle_Step,
    output logic [7:0] o_Cycle_Count,
    output logic [7:0] o_IR,
    output logic       o_Prefix_CB,
    output logic [3:0] o_Y,
    output logic [3:0] o_Conditions,
    output logic       o_Fault
);
    logic advance;
    logic unused_flags;
    assign advance = (o_Cycle_Step == STEP_T4) && !i_Stall;
    assign unused_flags = ^i_Flags[2:1];
    step_ring u_step_ring (
        .clk(i_Clk),
        .rst(i_Reset),
        .hold(i_Stall),
        .step(o_Cycle_Step)
    );
    // a load marks the new byte as CB-operand when the byte it replaces was an unprefixed CB
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            o_Cycle_Count <= COUNT_FIRST;
            o_IR <= OPC_NOP;
            o_Prefix_CB <= 1'b0;
            o_Fault <= 1'b0;
        end else if (advance) begin
            if (i_IR_Fetch) begin
                o_IR <= i_Data_Bus;
                o_Cycle_Count <= COUNT_FIRST;
                o_Prefix_CB <= (o_IR == OPC_CB) && !o_Prefix_CB;
            end else if (o_Cycle_Count == COUNT_LAST)
                o_Fault <= 1'b1;
            else
                o_Cycle_Count <= o_Cycle_Count << 1;
        end
    end
    always_comb begin
        o_Y = 4'b0001 << o_IR[4:3];
        o_Conditions = '0;
        o_Conditions[COND_NZ] = ~i_Flags[FLAG_Z];
        o_Conditions[COND_Z] = i_Flags[FLAG_Z];
        o_Conditions[COND_NC] = ~i_Flags[FLAG_C];
        o_Conditions[COND_C] = i_Flags[FLAG_C];
    end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed stimulus with a cycle-tagged scoreboard checked by a separate monitor
module tb_control_sequencer;
    logic       i_Clk = 1'b0;
    logic       i_Reset = 1'b1;
    logic       i_Stall = 1'b0;
    logic       i_IR_Fetch = 1'b0;
    logic [7:0] i_Data_Bus = 8'h00;
    logic [3:0] i_Flags = 4'b0000;
    logic [3:0] o_Cycle_Step;
    logic [7:0] o_Cycle_Count;
    logic [7:0] o_IR;
    logic       o_Prefix_CB;
    logic [3:0] o_Y;
    logic [3:0] o_Conditions;
    logic       o_Fault;

    control_sequencer dut (
        .i_Clk(i_Clk),
        .i_Reset(i_Reset),
        .i_Stall(i_Stall),
        .i_IR_Fetch(i_IR_Fetch),
        .i_Data_Bus(i_Data_Bus),
        .i_Flags(i_Flags),
        .o_Cycle_Step(o_Cycle_Step),
        .o_Cycle_Count(o_Cycle_Count),
        .o_IR(o_IR),
        .o_Prefix_CB(o_Prefix_CB),
        .o_Y(o_Y),
        .o_Conditions(o_Conditions),
        .o_Fault(o_Fault)
    );

    always #5 i_Clk = ~i_Clk;

    typedef struct {
        int         c;
        string      nm;
        logic [3:0] st;
        logic [7:0] cn;
        logic [7:0] ir;
        logic       pc;
        logic       ft;
        logic       dec;
        logic [3:0] y;
        logic [3:0] cd;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic push(string nm, logic [3:0] st, logic [7:0] cn, logic [7:0] ir, logic pc,
                        logic ft, logic dec, logic [3:0] y, logic [3:0] cd);
        exp_t e;
        e.c = cyc + 1;
        e.nm = nm;
        e.st = st;
        e.cn = cn;
        e.ir = ir;
        e.pc = pc;
        e.ft = ft;
        e.dec = dec;
        e.y = y;
        e.cd = cd;
        q.push_back(e);
    endtask

    task automatic es(string nm, logic [3:0] st, logic [7:0] cn, logic [7:0] ir, logic pc, logic ft);
        push(nm, st, cn, ir, pc, ft, 1'b0, 4'b0000, 4'b0000);
    endtask

    task automatic ed(string nm, logic [3:0] st, logic [7:0] cn, logic [7:0] ir, logic pc, logic ft,
                      logic [3:0] y, logic [3:0] cd);
        push(nm, st, cn, ir, pc, ft, 1'b1, y, cd);
    endtask

    task automatic tick(logic s, logic f, logic [7:0] d);
        i_Stall = s;
        i_IR_Fetch = f;
        i_Data_Bus = d;
        @(negedge i_Clk);
    endtask

    task automatic load(string nm, logic [7:0] d, logic pc, logic [3:0] y, logic [3:0] cd);
        repeat (3) tick(1'b0, 1'b0, 8'h00);
        ed(nm, 4'b0001, 8'h01, d, pc, 1'b0, y, cd);
        tick(1'b0, 1'b1, d);
    endtask

    always @(posedge i_Clk) begin
        exp_t e;
        logic ok;
        cyc++;
        #3;
        while (q.size() != 0 && q[0].c <= cyc) begin
            e = q.pop_front();
            ok = (e.c == cyc) && o_Cycle_Step == e.st && o_Cycle_Count == e.cn && o_IR == e.ir &&
                 o_Prefix_CB == e.pc && o_Fault == e.ft && (!e.dec || (o_Y == e.y && o_Conditions == e.cd));
            n_chk++;
            if (!ok) begin
                n_fail++;
                $display("FAIL %s cyc=%0d: got step=%b cnt=%h ir=%h pre=%b flt=%b y=%b cond=%b, want step=%b cnt=%h ir=%h pre=%b flt=%b y=%b cond=%b (dec %b)",
                         e.nm, cyc, o_Cycle_Step, o_Cycle_Count, o_IR, o_Prefix_CB, o_Fault, o_Y, o_Conditions,
                         e.st, e.cn, e.ir, e.pc, e.ft, e.y, e.cd, e.dec);
            end
        end
    end

    initial begin
        logic [3:0] ring [4];
        ring = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        ed("reset", 4'b0001, 8'h01, 8'h00, 1'b0, 1'b0, 4'b0001, 4'b0101);
        tick(1'b0, 1'b0, 8'h00);
        i_Reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            es("idle", ring[i % 4], 8'h01, 8'h00, 1'b0, 1'b0);
            tick(1'b0, 1'b1, 8'h00);
        end
        load("ld_jp_nz", 8'hC2, 1'b0, 4'b0001, 4'b0101);
        for (int k = 1; k <= 16; k++) begin
            if (k == 16) begin
                i_Flags = 4'b1000;
                ed("ld_jp_nz_z1", 4'b0001, 8'h01, 8'hC2, 1'b0, 1'b0, 4'b0001, 4'b0110);
            end else if (k % 4 == 0)
                es("jp_nz_count", 4'b0001, 8'h01 << (k / 4), 8'hC2, 1'b0, 1'b0);
            else if (k == 15)
                es("fetch_ignored_t3", 4'b1000, 8'h08, 8'hC2, 1'b0, 1'b0);
            tick(1'b0, k >= 13, k == 16 ? 8'hC2 : 8'hFF);
        end
        for (int k = 1; k <= 12; k++) begin
            if (k == 12)
                ed("ld_cb", 4'b0001, 8'h01, 8'hCB, 1'b0, 1'b0, 4'b0010, 4'b0110);
            else if (k % 4 == 0)
                es("jp_z_count", 4'b0001, 8'h01 << (k / 4), 8'hC2, 1'b0, 1'b0);
            tick(1'b0, k == 12, k == 12 ? 8'hCB : 8'h00);
        end
        i_Flags = 4'b0001;
        load("cb_37", 8'h37, 1'b1, 4'b0100, 4'b1001);
        load("cb_clear", 8'h00, 1'b0, 4'b0001, 4'b1001);
        load("cbcb_first", 8'hCB, 1'b0, 4'b0010, 4'b1001);
        load("cbcb_second", 8'hCB, 1'b1, 4'b0010, 4'b1001);
        load("cbcb_clear", 8'h00, 1'b0, 4'b0001, 4'b1001);
        for (int k = 1; k <= 4; k++) begin
            if (k == 4)
                es("pre_stall", 4'b0001, 8'h02, 8'h00, 1'b0, 1'b0);
            tick(1'b0, 1'b0, 8'h00);
        end
        es("enter_t2", 4'b0010, 8'h02, 8'h00, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 3; k++) begin
            es("stall_t2", 4'b0010, 8'h02, 8'h00, 1'b0, 1'b0);
            tick(1'b1, 1'b1, 8'hAA);
        end
        es("post_stall_t3", 4'b0100, 8'h02, 8'h00, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 8'h00);
        es("post_stall_t4", 4'b1000, 8'h02, 8'h00, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 8'h00);
        es("stall_t4_blocks_load", 4'b1000, 8'h02, 8'h00, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 8'hAA);
        ed("ld_after_stall", 4'b0001, 8'h01, 8'h3E, 1'b0, 1'b0, 4'b1000, 4'b1001);
        tick(1'b0, 1'b1, 8'h3E);
        for (int k = 1; k <= 36; k++) begin
            if (k % 4 == 0)
                es("overflow", 4'b0001, (k / 4) < 8 ? 8'h01 << (k / 4) : 8'h80, 8'h3E, 1'b0, (k / 4) >= 8);
            tick(1'b0, 1'b0, 8'h00);
        end
        tick(1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 8'h00);
        es("stall_t3_fault", 4'b0100, 8'h80, 8'h3E, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 8'h00);
        i_Reset = 1'b1;
        ed("reset_mid_stall", 4'b0001, 8'h01, 8'h00, 1'b0, 1'b0, 4'b0001, 4'b1001);
        tick(1'b1, 1'b0, 8'h00);
        i_Reset = 1'b0;
        es("after_reset", 4'b0010, 8'h01, 8'h00, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 8'h00);
        repeat (3) @(negedge i_Clk);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
